// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage pipelined RISC-V core.
//
// Owns the PC register and the IF/ID pipeline register. It applies the ID stage's
// stall (load-use hold) and flush (taken-branch redirect plus bubble) requests, and
// keeps saturating counters of the stall and flush events it has applied.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-high reset
//   start_i        run enable; when low, every register holds
//   stall_i        hold PC and IF/ID for this cycle
//   flush_i        redirect PC to branch_addr_i and bubble IF/ID (beats stall_i)
//   branch_addr_i  branch target from ID; the low two bits are ignored
//   instr_i        instruction-memory read data for instr_addr_o (combinational memory)
//   instr_addr_o   instruction-memory address (the PC register)
//   pc_o           current PC register
//   ifid_addr_o    PC of the instruction held in IF/ID
//   ifid_instr_o   instruction held in IF/ID
//   ifid_valid_o   IF/ID holds a real fetched instruction (0 for a bubble)
//   stall_cnt_o    saturating count of applied stall cycles
//   flush_cnt_o    saturating count of applied flush cycles
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      branch_addr_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      instr_addr_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_addr_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [31:0]      r_pc;
  logic [31:0]      r_ifid_addr;
  logic [31:0]      r_ifid_instr;
  logic             r_ifid_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters stop at all-ones rather than wrapping.
  logic w_stall_sat;
  logic w_flush_sat;
  assign w_stall_sat = &r_stall_cnt;
  assign w_flush_sat = &r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc         <= RESET_PC;
      r_ifid_addr  <= 32'h0000_0000;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else if (start_i) begin
      if (flush_i) begin
        // Redirect wins over a simultaneous stall; the stall is not counted.
        r_pc         <= {branch_addr_i[31:2], 2'b00};
        r_ifid_addr  <= 32'h0000_0000;
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
        if (!w_flush_sat) begin
          r_flush_cnt <= r_flush_cnt + CntOne;
        end
      end else if (stall_i) begin
        if (!w_stall_sat) begin
          r_stall_cnt <= r_stall_cnt + CntOne;
        end
      end else begin
        r_pc         <= r_pc + 32'd4;
        r_ifid_addr  <= r_pc;
        r_ifid_instr <= instr_i;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  assign instr_addr_o = r_pc;
  assign pc_o         = r_pc;
  assign ifid_addr_o  = r_ifid_addr;
  assign ifid_instr_o = r_ifid_instr;
  assign ifid_valid_o = r_ifid_valid;
  assign stall_cnt_o  = r_stall_cnt;
  assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then randomized
// start/stall/flush/reset traffic compared every cycle against a behavioural model.
// A second instance with 2-bit counters exercises counter saturation.
module tb_if_stage;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam logic [31:0] Nop   = 32'h0000_0013;
  localparam logic [31:0] InA   = 32'h1111_1111;
  localparam logic [31:0] InB   = 32'h2222_2222;
  localparam logic [31:0] InC   = 32'h3333_3333;
  localparam logic [31:0] InD   = 32'h4444_4444;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] br = 32'h0;
  logic [31:0] instr;

  logic [31:0] addr, pc, ifa, ifi;
  logic        ifv;
  logic [31:0] scnt, fcnt;

  logic [31:0] addr2, pc2, ifa2, ifi2;
  logic        ifv2;
  logic [1:0]  scnt2, fcnt2;
  logic [31:0] instr2;

  logic [31:0] imem [256];

  assign instr  = imem[addr[9:2]];
  assign instr2 = imem[addr2[9:2]];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RstPc), .NOP_INSTR(Nop), .CNT_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_addr_i(br), .instr_i(instr), .instr_addr_o(addr), .pc_o(pc),
    .ifid_addr_o(ifa), .ifid_instr_o(ifi), .ifid_valid_o(ifv),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  if_stage #(.RESET_PC(RstPc), .NOP_INSTR(Nop), .CNT_W(2)) u_dut_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_addr_i(br), .instr_i(instr2), .instr_addr_o(addr2), .pc_o(pc2),
    .ifid_addr_o(ifa2), .ifid_instr_o(ifi2), .ifid_valid_o(ifv2),
    .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: architectural state with unbounded event counts.
  logic [31:0] m_pc, m_ifa, m_ifi;
  logic        m_ifv;
  longint      m_sn, m_fn;

  function automatic logic [31:0] sat(input longint n, input longint maxv);
    return (n > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc  <= RstPc;
      m_ifa <= 32'h0;
      m_ifi <= Nop;
      m_ifv <= 1'b0;
      m_sn  <= 0;
      m_fn  <= 0;
    end else if (start) begin
      if (flush) begin
        m_pc  <= br - (br % 4);
        m_ifa <= 32'h0;
        m_ifi <= Nop;
        m_ifv <= 1'b0;
        m_fn  <= m_fn + 1;
      end else if (stall) begin
        m_sn <= m_sn + 1;
      end else begin
        m_ifa <= m_pc;
        m_ifi <= imem[m_pc[9:2]];
        m_ifv <= 1'b1;
        m_pc  <= 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
      end
    end
  end

  // Per-cycle comparison, half a period away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_pc", pc, m_pc);
      check("cmp_addr", addr, m_pc);
      check("cmp_ifid_addr", ifa, m_ifa);
      check("cmp_ifid_instr", ifi, m_ifi);
      check("cmp_ifid_valid", {31'b0, ifv}, {31'b0, m_ifv});
      check("cmp_stall_cnt", scnt, sat(m_sn, 64'hFFFF_FFFF));
      check("cmp_flush_cnt", fcnt, sat(m_fn, 64'hFFFF_FFFF));
      check("cmp_small_pc", pc2, m_pc);
      check("cmp_small_stall_cnt", {30'b0, scnt2}, sat(m_sn, 3));
      check("cmp_small_flush_cnt", {30'b0, fcnt2}, sat(m_fn, 3));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string name, input logic [31:0] a, input logic [31:0] i,
                          input logic v);
    check({name, "_addr"}, ifa, a);
    check({name, "_instr"}, ifi, i);
    check({name, "_valid"}, {31'b0, ifv}, {31'b0, v});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = InA;
    imem[1] = InB;
    imem[2] = InC;
    imem[3] = InD;

    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_pc", pc, RstPc);
    chk_ifid("rst_ifid", 32'h0, Nop, 1'b0);
    check("rst_stall_cnt", scnt, 32'h0);
    check("rst_flush_cnt", fcnt, 32'h0);

    rst = 1'b0;
    start = 1'b1;
    cyc();
    check("run1_pc", pc, 32'h4);
    chk_ifid("run1_ifid", 32'h0, InA, 1'b1);
    cyc();
    check("run2_pc", pc, 32'h8);
    chk_ifid("run2_ifid", 32'h4, InB, 1'b1);
    check("run2_cnts", scnt | fcnt, 32'h0);

    stall = 1'b1;
    cyc();
    cyc();
    check("stall_pc", pc, 32'h8);
    chk_ifid("stall_ifid", 32'h4, InB, 1'b1);
    check("stall_cnt2", scnt, 32'd2);
    stall = 1'b0;
    cyc();
    check("unstall_pc", pc, 32'hC);
    chk_ifid("unstall_ifid", 32'h8, InC, 1'b1);

    flush = 1'b1;
    br = 32'h0000_0022;
    cyc();
    check("flush_pc", pc, 32'h20);
    chk_ifid("flush_ifid", 32'h0, Nop, 1'b0);
    check("flush_cnt1", fcnt, 32'd1);
    flush = 1'b0;
    cyc();
    chk_ifid("after_flush_ifid", 32'h20, imem[8], 1'b1);

    flush = 1'b1;
    stall = 1'b1;
    br = 32'h40;
    cyc();
    check("fs_pc", pc, 32'h40);
    chk_ifid("fs_ifid", 32'h0, Nop, 1'b0);
    check("fs_flush_cnt", fcnt, 32'd2);
    check("fs_stall_cnt", scnt, 32'd2);
    flush = 1'b0;
    start = 1'b0;
    cyc();
    check("nostart_pc", pc, 32'h40);
    check("nostart_stall_cnt", scnt, 32'd2);
    start = 1'b1;
    stall = 1'b0;

    flush = 1'b1;
    br = 32'hFFFF_FFFC;
    cyc();
    check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    flush = 1'b0;
    cyc();
    check("wrap_pc", pc, 32'h0);
    chk_ifid("wrap_ifid", 32'hFFFF_FFFC, imem[255], 1'b1);

    stall = 1'b1;
    repeat (5) cyc();
    check("sat_small_cnt", {30'b0, scnt2}, 32'd3);
    check("big_stall_cnt", scnt, 32'd7);
    cyc();
    check("sat_small_held", {30'b0, scnt2}, 32'd3);
    stall = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 6) == 0);
      stall = ($urandom_range(0, 4) == 0);
      br = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      cyc();
    end

    start = 1'b1;
    stall = 1'b0;
    flush = 1'b1;
    br = 32'h1C;
    cyc();
    flush = 1'b0;
    stall = 1'b1;
    cyc();
    check("pre_rst_pc", pc, 32'h1C);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pc", pc, RstPc);
    check("midrst_addr", addr, RstPc);
    chk_ifid("midrst_ifid", 32'h0, Nop, 1'b0);
    check("midrst_cnts", scnt | fcnt, 32'h0);
    check("midrst_small_cnts", {30'b0, scnt2 | fcnt2}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
    cyc();
    cyc();
    check("restart_pc", pc, 32'h8);
    chk_ifid("restart_ifid", 32'h4, InB, 1'b1);

    cyc();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
